mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage access controller, directly downstream of the EX/MEM pipeline latch.
- Consumes the EXME fields (REN/WEN, address, store data, llsc, halt) and drives the data-cache request.
- Holds the pipeline until the access completes, then returns load data and a completion strobe for the MEM/WB latch.
- Owns the per-core LL/SC link register, including snoop invalidation from the other core.

Parameters:
- WORD_W, 32, data/address width (matches word_t).
- LINK_EN, 1, 1 = LL/SC supported; 0 = llsc_EXME ignored, and LL/SC behave as LW/SW.

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- cu_dmemREN_EXME  in  1  load in MEM stage.
- cu_dmemWEN_EXME  in  1  store in MEM stage.
- dmemaddr_EXME  in  WORD_W  access address.
- dmemstore_EXME  in  WORD_W  store data.
- llsc_EXME  in  1  access is LL (with REN) or SC (with WEN).
- halt_EXME  in  1  halt in MEM stage.
- pipe_en  in  1  EX/MEM latch advances this cycle (0 = held by hazard unit).
- dhit  in  1  cache completes current request.
- dload  in  WORD_W  cache read data, valid with dhit.
- ccinv  in  1  coherence invalidate from the other core.
- ccsnoopaddr  in  WORD_W  invalidate address.
- dREN  out  1  cache read request.
- dWEN  out  1  cache write request.
- daddr  out  WORD_W  cache address.
- dstore  out  WORD_W  cache write data.
- mem_stall  out  1  hold IF..MEM stages.
- mem_done  out  1  access finished this cycle (feeds dhit_MEWB).
- dmemload_out  out  WORD_W  load data / SC result (feeds dmemload_MEWB).

Behaviour:
- Clock/reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, link_valid=0, link_addr=0, load_q=0. All outputs 0 during reset; dmemload_out=0.
- Definitions:
  - acc = (REN|WEN) & ~halt_EXME.
  - sc = WEN & llsc & LINK_EN.
  - sc_ok = link_valid & (link_addr == dmemaddr_EXME).
- States: IDLE, BUSY, DONE.
- IDLE:
  - If acc and not (sc & ~sc_ok): drive dREN=REN, dWEN=WEN, daddr=dmemaddr_EXME, dstore=dmemstore_EXME.
  - mem_stall = ~dhit.
  - On dhit: mem_done=1, dmemload_out=dload (sc: 32'd1), load_q captured; next state = pipe_en ? IDLE : DONE.
  - If no dhit: next state BUSY.
- SC fail (sc & ~sc_ok) in IDLE:
  - No cache request; mem_stall=0, mem_done=1, dmemload_out=0, same cycle.
  - Next state = pipe_en ? IDLE : DONE.
- BUSY:
  - Request held stable (same daddr/dstore/REN/WEN) until dhit.
  - mem_stall=1 until the dhit cycle, where mem_stall=0 and mem_done=1.
  - Transitions as in IDLE.
  - No timeout; minimum latency 0 extra cycles (dhit in issue cycle).
- DONE:
  - Instruction still in EXME because the pipeline is held: no reissue, dREN=dWEN=0, mem_stall=0, mem_done=0.
  - dmemload_out=load_q.
  - Return to IDLE on pipe_en=1.
- Halt: halt_EXME=1 forces no request, mem_stall=0, mem_done=0. An in-flight BUSY access still completes first; halt is sampled only in IDLE.
- Link register, updated on the completing cycle:
  - LL (REN&llsc) dhit: link_valid=1, link_addr=daddr.
  - SC, success or fail: link_valid=0.
  - Plain SW dhit to link_addr: link_valid=0.
  - ccinv & ccsnoopaddr==link_addr: link_valid=0, any cycle.
  - Same-cycle LL set and ccinv to the same address: ccinv wins, link_valid=0.
- Address compare: full WORD_W equality; bits [1:0] included (word-aligned accesses only).
- Reset mid-access: drops request immediately, returns to IDLE, clears link.

Test Plan:
- LW addr 0x100, dhit after 3 cycles, dload=0xDEADBEEF: dREN=1 for 4 cycles; mem_stall=1 for 3 cycles; mem_done and dmemload_out=0xDEADBEEF on 4th; no reissue.
- LW with dhit in issue cycle, pipe_en=0 for 2 cycles: mem_done 1 cycle; DONE holds dmemload_out=load value; dREN=0 until pipe_en=1, then IDLE.
- LL 0x200 then SC 0x200 data 0x5: SC issues dWEN, dmemload_out=1, link_valid=0. A second SC to 0x200 gives no dWEN, mem_done same cycle, dmemload_out=0.
- LL 0x200; ccinv with ccsnoopaddr=0x200; SC 0x200: SC fails, dWEN never asserted, dmemload_out=0. Repeat with snoop 0x204: SC succeeds.
- halt_EXME=1 with REN=1: dREN=0, mem_stall=0. Assert nRST=0 during BUSY: all outputs 0 asynchronously; state IDLE; link cleared.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: issues the data-cache request for the EX/MEM
// instruction, stalls until completion, and maintains the LL/SC link register.
module mem_stage_ctrl #(
    parameter int WORD_W  = 32,
    parameter bit LINK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              cu_dmemREN_EXME,
    input  logic              cu_dmemWEN_EXME,
    input  logic [WORD_W-1:0] dmemaddr_EXME,
    input  logic [WORD_W-1:0] dmemstore_EXME,
    input  logic              llsc_EXME,
    input  logic              halt_EXME,
    input  logic              pipe_en,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              mem_stall,
    output logic              mem_done,
    output logic [WORD_W-1:0] dmemload_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;
    logic [WORD_W-1:0] load_q, load_d;

    // Request captured at issue so BUSY drives a stable request to the cache.
    logic              req_ren_q, req_ren_d;
    logic              req_wen_q, req_wen_d;
    logic              req_llsc_q, req_llsc_d;
    logic [WORD_W-1:0] req_addr_q, req_addr_d;
    logic [WORD_W-1:0] req_data_q, req_data_d;

    logic              dren_c, dwen_c, stall_c, done_c;
    logic [WORD_W-1:0] daddr_c, dstore_c, load_out_c;

    logic              complete;
    logic              cur_ren, cur_wen, cur_llsc;
    logic [WORD_W-1:0] cur_addr, result;

    logic acc, sc_now, sc_ok;

    assign acc    = (cu_dmemREN_EXME | cu_dmemWEN_EXME) & ~halt_EXME;
    assign sc_now = cu_dmemWEN_EXME & llsc_EXME & LINK_EN;
    assign sc_ok  = link_valid_q & (link_addr_q == dmemaddr_EXME);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        load_d       = load_q;
        req_ren_d    = req_ren_q;
        req_wen_d    = req_wen_q;
        req_llsc_d   = req_llsc_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        dren_c       = 1'b0;
        dwen_c       = 1'b0;
        daddr_c      = '0;
        dstore_c     = '0;
        stall_c      = 1'b0;
        done_c       = 1'b0;
        load_out_c   = '0;
        complete     = 1'b0;
        cur_ren      = 1'b0;
        cur_wen      = 1'b0;
        cur_llsc     = 1'b0;
        cur_addr     = '0;
        result       = '0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (sc_now & ~sc_ok) begin
                        // Failed SC resolves locally: no cache traffic.
                        done_c       = 1'b1;
                        load_d       = '0;
                        link_valid_d = 1'b0;
                        state_d      = pipe_en ? IDLE : DONE;
                    end else begin
                        dren_c     = cu_dmemREN_EXME;
                        dwen_c     = cu_dmemWEN_EXME;
                        daddr_c    = dmemaddr_EXME;
                        dstore_c   = dmemstore_EXME;
                        stall_c    = ~dhit;
                        req_ren_d  = cu_dmemREN_EXME;
                        req_wen_d  = cu_dmemWEN_EXME;
                        req_llsc_d = llsc_EXME;
                        req_addr_d = dmemaddr_EXME;
                        req_data_d = dmemstore_EXME;
                        cur_ren    = cu_dmemREN_EXME;
                        cur_wen    = cu_dmemWEN_EXME;
                        cur_llsc   = llsc_EXME;
                        cur_addr   = dmemaddr_EXME;
                        if (dhit) complete = 1'b1;
                        else      state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                dren_c   = req_ren_q;
                dwen_c   = req_wen_q;
                daddr_c  = req_addr_q;
                dstore_c = req_data_q;
                stall_c  = ~dhit;
                cur_ren  = req_ren_q;
                cur_wen  = req_wen_q;
                cur_llsc = req_llsc_q;
                cur_addr = req_addr_q;
                if (dhit) complete = 1'b1;
            end
            DONE: begin
                load_out_c = load_q;
                if (pipe_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            result     = (cur_wen & cur_llsc & LINK_EN) ? {{(WORD_W-1){1'b0}}, 1'b1} : dload;
            done_c     = 1'b1;
            load_out_c = result;
            load_d     = result;
            state_d    = pipe_en ? IDLE : DONE;
            if (cur_ren & cur_llsc & LINK_EN) begin
                link_valid_d = 1'b1;
                link_addr_d  = cur_addr;
            end else if (cur_wen & cur_llsc & LINK_EN) begin
                link_valid_d = 1'b0;
            end else if (cur_wen && (cur_addr == link_addr_q)) begin
                link_valid_d = 1'b0;
            end
        end

        // Snoop checked against the post-update link so it also beats a same-cycle LL.
        if (ccinv && (ccsnoopaddr == link_addr_d)) link_valid_d = 1'b0;
    end

    // Outputs forced low while reset is asserted, independent of the clock.
    assign dREN         = nRST & dren_c;
    assign dWEN         = nRST & dwen_c;
    assign mem_stall    = nRST & stall_c;
    assign mem_done     = nRST & done_c;
    assign daddr        = nRST ? daddr_c    : '0;
    assign dstore       = nRST ? dstore_c   : '0;
    assign dmemload_out = nRST ? load_out_c : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            load_q       <= '0;
            req_ren_q    <= 1'b0;
            req_wen_q    <= 1'b0;
            req_llsc_q   <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            load_q       <= load_d;
            req_ren_q    <= req_ren_d;
            req_wen_q    <= req_wen_d;
            req_llsc_q   <= req_llsc_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a transaction-level driver with a link
// register model queues expected completions; a monitor checks the DUT outputs.
module tb_mem_stage_ctrl;

    localparam int OP_LW = 0, OP_SW = 1, OP_LL = 2, OP_SC = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        cu_dmemREN_EXME, cu_dmemWEN_EXME, llsc_EXME, halt_EXME;
    logic [31:0] dmemaddr_EXME, dmemstore_EXME;
    logic        pipe_en, dhit, ccinv;
    logic [31:0] dload, ccsnoopaddr;
    logic        dREN, dWEN, mem_stall, mem_done;
    logic [31:0] daddr, dstore, dmemload_out;

    mem_stage_ctrl #(.WORD_W(32), .LINK_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .cu_dmemREN_EXME(cu_dmemREN_EXME), .cu_dmemWEN_EXME(cu_dmemWEN_EXME),
        .dmemaddr_EXME(dmemaddr_EXME), .dmemstore_EXME(dmemstore_EXME),
        .llsc_EXME(llsc_EXME), .halt_EXME(halt_EXME), .pipe_en(pipe_en),
        .dhit(dhit), .dload(dload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mem_stall(mem_stall), .mem_done(mem_done), .dmemload_out(dmemload_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen;
        logic [31:0] addr, wdata, rdata;
        int          stalls, req_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Link register model at access granularity.
    bit          m_valid = 1'b0;
    logic [31:0] m_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_fields();
        cu_dmemREN_EXME = 1'b0; cu_dmemWEN_EXME = 1'b0; llsc_EXME = 1'b0;
        halt_EXME = 1'b0; dhit = 1'b0; ccinv = 1'b0; pipe_en = 1'b1;
        dmemaddr_EXME = $urandom; dmemstore_EXME = $urandom; dload = $urandom;
    endtask

    // One memory instruction: dhit after d wait cycles, then h cycles held in MEM.
    task automatic do_access(input int op, input logic [31:0] addr, input int d,
                             input int h, input bit inv_done);
        exp_t        e;
        logic [31:0] rdata;
        bit          is_ren, is_sc, sc_fail;
        is_ren  = (op == OP_LW) || (op == OP_LL);
        is_sc   = (op == OP_SC);
        sc_fail = is_sc && !(m_valid && (m_addr == addr));
        rdata   = $urandom;
        e.ren   = is_ren;
        e.wen   = !is_ren;
        e.addr  = addr;
        e.wdata = $urandom;
        if (sc_fail) begin
            e.rdata = 0; e.stalls = 0; e.req_cycles = 0;
            m_valid = 1'b0;
        end else begin
            e.rdata = is_sc ? 32'd1 : rdata;
            e.stalls = d; e.req_cycles = d + 1;
            if (op == OP_LL) begin
                m_valid = 1'b1; m_addr = addr;
            end else if (is_sc) begin
                m_valid = 1'b0;
            end else if (!is_ren && addr == m_addr) begin
                m_valid = 1'b0;
            end
            if (inv_done && addr == m_addr) m_valid = 1'b0;
        end
        exp_q.push_back(e);

        cu_dmemREN_EXME = is_ren;
        cu_dmemWEN_EXME = !is_ren;
        llsc_EXME       = (op == OP_LL) || is_sc;
        dmemaddr_EXME   = addr;
        dmemstore_EXME  = e.wdata;
        if (sc_fail) begin
            dhit = 1'b0; pipe_en = (h == 0);
            step();
        end else begin
            for (int k = 0; k <= d; k++) begin
                dhit        = (k == d);
                dload       = (k == d) ? rdata : $urandom;
                pipe_en     = (k == d) && (h == 0);
                ccinv       = inv_done && (k == d);
                ccsnoopaddr = addr;
                step();
                ccinv = 1'b0;
            end
        end
        for (int j = 0; j < h; j++) begin
            dhit = 1'b0; dload = $urandom; pipe_en = (j == h - 1);
            step();
        end
        clear_fields();
    endtask

    task automatic do_snoop(input logic [31:0] addr);
        ccinv = 1'b1; ccsnoopaddr = addr;
        if (addr == m_addr) m_valid = 1'b0;
        step();
        ccinv = 1'b0;
    endtask

    task automatic do_halt(input bit as_load);
        cu_dmemREN_EXME = as_load; cu_dmemWEN_EXME = !as_load;
        llsc_EXME = $urandom_range(0, 1); halt_EXME = 1'b1;
        dmemaddr_EXME = 32'h100; dhit = $urandom_range(0, 1);
        step();
        clear_fields();
    endtask

    // Monitor: pops one expectation per completion and audits the request it saw.
    initial begin
        int  req_cnt, stall_cnt, wait_cnt;
        bit  req_bad, holding;
        logic [31:0] hold_val;
        exp_t head;
        req_cnt = 0; stall_cnt = 0; wait_cnt = 0; req_bad = 0; holding = 0; hold_val = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                req_cnt = 0; stall_cnt = 0; wait_cnt = 0; req_bad = 0; holding = 0;
            end else if (holding) begin
                check("hold_data", dmemload_out, hold_val);
                check("hold_quiet", {28'd0, dREN, dWEN, mem_stall, mem_done}, 32'd0);
                if (pipe_en) holding = 0;
            end else if (exp_q.size() == 0) begin
                check("idle_quiet", {28'd0, dREN, dWEN, mem_stall, mem_done}, 32'd0);
            end else begin
                head = exp_q[0];
                wait_cnt++;
                if (dREN || dWEN) begin
                    req_cnt++;
                    if (dREN !== head.ren || dWEN !== head.wen ||
                        daddr !== head.addr || dstore !== head.wdata) req_bad = 1;
                end
                if (mem_stall) stall_cnt++;
                if (mem_done) begin
                    void'(exp_q.pop_front());
                    check("load_data", dmemload_out, head.rdata);
                    check("stall_cycles", stall_cnt, head.stalls);
                    check("req_cycles", req_cnt, head.req_cycles);
                    check("req_fields", {31'd0, req_bad}, 32'd0);
                    check("done_no_stall", {31'd0, mem_stall}, 32'd0);
                    if (!pipe_en) begin
                        holding = 1; hold_val = head.rdata;
                    end
                    req_cnt = 0; stall_cnt = 0; wait_cnt = 0; req_bad = 0;
                end else if (wait_cnt > 64) begin
                    check("completion_timeout", wait_cnt, 0);
                    void'(exp_q.pop_front());
                    req_cnt = 0; stall_cnt = 0; wait_cnt = 0; req_bad = 0;
                end
            end
        end
    end

    initial begin
        int op;
        logic [31:0] a;
        nRST = 1'b0;
        clear_fields();
        ccsnoopaddr = '0;
        #2;
        check("rst_outputs", {dREN, dWEN, mem_stall, mem_done, daddr[27:0]}, 32'd0);
        check("rst_load", dmemload_out, 32'd0);
        repeat (2) step();
        nRST = 1'b1;
        step();

        do_access(OP_LW, 32'h100, 3, 0, 0);
        do_access(OP_LW, 32'h104, 0, 2, 0);
        do_access(OP_LL, 32'h200, 1, 0, 0);
        do_access(OP_SC, 32'h200, 2, 0, 0);
        do_access(OP_SC, 32'h200, 1, 1, 0);
        do_access(OP_LL, 32'h200, 0, 0, 0);
        do_snoop(32'h200);
        do_access(OP_SC, 32'h200, 1, 0, 0);
        do_access(OP_LL, 32'h200, 2, 0, 0);
        do_snoop(32'h204);
        do_access(OP_SC, 32'h200, 0, 0, 0);
        do_halt(1'b1);
        do_halt(1'b0);
        do_access(OP_LL, 32'h210, 1, 0, 1);
        do_access(OP_SC, 32'h210, 0, 0, 0);
        do_access(OP_LL, 32'h204, 0, 0, 0);
        do_access(OP_SW, 32'h204, 1, 0, 0);
        do_access(OP_SC, 32'h204, 0, 0, 0);

        // Reset in the middle of a pending load; the link must be cleared.
        do_access(OP_LL, 32'h300, 0, 0, 0);
        exp_q.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h104, wdata: 32'h0,
                          rdata: 32'h0, stalls: 0, req_cycles: 0});
        cu_dmemREN_EXME = 1'b1; dmemaddr_EXME = 32'h104; dmemstore_EXME = 32'h0;
        dhit = 1'b0; pipe_en = 1'b0;
        repeat (2) step();
        #2 nRST = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        #1;
        check("rst_mid_ctrl", {28'd0, dREN, dWEN, mem_stall, mem_done}, 32'd0);
        check("rst_mid_addr", daddr, 32'd0);
        check("rst_mid_load", dmemload_out, 32'd0);
        clear_fields();
        repeat (2) step();
        nRST = 1'b1;
        step();
        do_access(OP_SC, 32'h300, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 5);
            a  = 32'h100 + 4 * $urandom_range(0, 3);
            case (op)
                4:       do_halt($urandom_range(0, 1));
                5:       do_snoop(a);
                default: do_access(op, a, $urandom_range(0, 3), $urandom_range(0, 2),
                                   (op == OP_LL) && ($urandom_range(0, 3) == 0));
            endcase
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
